// File: rtl/hazardunit.sv
// hazardunit: stall/flush controller for the five-stage semiMIPS pipeline.
// Resolves the hazards forwarding cannot cover: load-use stalls, branch/jump
// flushes and data-memory wait freezes. Also keeps a registered cause history
// and a memory-wait watchdog.
//
// Optional feature macro: HAZARD_STATS_EN adds the stallcnt/flushcnt outputs.
//
// Parameters:
//   MEMTIMEOUT   consecutive freeze cycles before memerr is raised (2..255)
// Ports:
//   clk          pipeline clock, rising edge
//   rstn         asynchronous active-low reset
//   idexmemrd    ID/EX holds a load
//   idexrt       destination register of the instruction in ID/EX
//   ifidins      instruction in IF/ID (opcode [31:26], rs [25:21], rt [20:16])
//   idjump       jump decoded in ID
//   exbranch     branch resolved taken in EX
//   exmemmemacc  EX/MEM performs a data-memory access
//   memready     data memory completes the access this cycle
//   pcwr         PC write enable (combinational)
//   ifidwr       IF/ID write enable (combinational)
//   pipewr       ID/EX, EX/MEM, MEM/WB write enable (combinational)
//   ifidflush    load a NOP into IF/ID (combinational)
//   idexflush    load a bubble into ID/EX (combinational)
//   hzstate      registered cause of the previous cycle
//   memerr       sticky memory-wait timeout flag
//   stallcnt     saturating LDSTALL cycle count (HAZARD_STATS_EN only)
//   flushcnt     saturating IF/ID flush cycle count (HAZARD_STATS_EN only)

module hazardunit #(
    parameter int unsigned MEMTIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        idexmemrd,
    input  logic [4:0]  idexrt,
    input  logic [31:0] ifidins,
    input  logic        idjump,
    input  logic        exbranch,
    input  logic        exmemmemacc,
    input  logic        memready,
    output logic        pcwr,
    output logic        ifidwr,
    output logic        pipewr,
    output logic        ifidflush,
    output logic        idexflush,
    output logic [1:0]  hzstate,
    output logic        memerr
`ifdef HAZARD_STATS_EN
    ,
    output logic [15:0] stallcnt,
    output logic [15:0] flushcnt
`endif
);

    localparam int unsigned CNT_W  = 8;
    localparam int unsigned STAT_W = 16;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;

    localparam logic [CNT_W-1:0] WAIT_MAX  = CNT_W'(MEMTIMEOUT);
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(MEMTIMEOUT - 1);

    typedef enum logic [1:0] {
        HZ_RUN     = 2'b00,
        HZ_LDSTALL = 2'b01,
        HZ_FLUSH   = 2'b10,
        HZ_FREEZE  = 2'b11
    } hz_e;

    logic [5:0]       opcode;
    logic [4:0]       rs;
    logic [4:0]       rt;
    logic             rs_used;
    logic             rt_used;
    logic             freeze;
    logic             lduse;
    hz_e              cause;
    hz_e              hz_q;
    logic [CNT_W-1:0] waitcnt;
    logic             unused_ins;

    assign opcode     = ifidins[31:26];
    assign rs         = ifidins[25:21];
    assign rt         = ifidins[20:16];
    assign unused_ins = ^ifidins[15:0];

    // Hazard detection: rt only counts as a source for R-type and beq/bne;
    // store data in rt is covered by MEM/WB forwarding.
    assign rs_used = (opcode != OP_J) && (opcode != OP_JAL);
    assign rt_used = (opcode == OP_RTYPE) || (opcode == OP_BEQ) || (opcode == OP_BNE);
    assign freeze  = exmemmemacc && !memready;
    assign lduse   = idexmemrd && (idexrt != 5'd0) &&
                     ((rs_used && (rs == idexrt)) || (rt_used && (rt == idexrt)));

    // Priority resolution; everything is forced off while reset is held.
    always_comb begin
        cause     = HZ_RUN;
        pcwr      = 1'b0;
        ifidwr    = 1'b0;
        pipewr    = 1'b0;
        ifidflush = 1'b0;
        idexflush = 1'b0;
        if (rstn) begin
            if (freeze) begin
                cause = HZ_FREEZE;
            end else if (exbranch) begin
                cause     = HZ_FLUSH;
                pcwr      = 1'b1;
                ifidwr    = 1'b1;
                pipewr    = 1'b1;
                ifidflush = 1'b1;
                idexflush = 1'b1;
            end else if (lduse) begin
                // Bubble into ID/EX while PC and IF/ID hold; the jump (if any)
                // simply re-decodes next cycle.
                cause     = HZ_LDSTALL;
                pipewr    = 1'b1;
                idexflush = 1'b1;
            end else if (idjump) begin
                cause     = HZ_FLUSH;
                pcwr      = 1'b1;
                ifidwr    = 1'b1;
                pipewr    = 1'b1;
                ifidflush = 1'b1;
            end else begin
                pcwr   = 1'b1;
                ifidwr = 1'b1;
                pipewr = 1'b1;
            end
        end
    end

    // Cause history and memory-wait watchdog.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            hz_q    <= HZ_RUN;
            waitcnt <= '0;
            memerr  <= 1'b0;
        end else begin
            hz_q <= cause;
            if (freeze) begin
                if (waitcnt != WAIT_MAX) begin
                    waitcnt <= waitcnt + CNT_W'(1);
                end
                if (waitcnt == WAIT_LAST) begin
                    memerr <= 1'b1;
                end
            end else begin
                waitcnt <= '0;
            end
        end
    end

    assign hzstate = hz_q;

`ifdef HAZARD_STATS_EN
    // Saturating event counters, cleared only by reset.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            stallcnt <= '0;
            flushcnt <= '0;
        end else begin
            if ((cause == HZ_LDSTALL) && (stallcnt != {STAT_W{1'b1}})) begin
                stallcnt <= stallcnt + STAT_W'(1);
            end
            if (ifidflush && (flushcnt != {STAT_W{1'b1}})) begin
                flushcnt <= flushcnt + STAT_W'(1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_hazardunit.sv
// tb_hazardunit: directed and randomized checks of hazardunit against a
// behavioural model (priority table, freeze-streak length, event tallies).
//   Clock: 10-unit period. Inputs change 1 unit after a rising edge;
//   combinational outputs are sampled 1 unit later, registered outputs
//   1 unit after the next rising edge.

module tb_hazardunit;

    localparam int unsigned MT = 4;

    logic        clk = 1'b0;
    logic        rstn;
    logic        idexmemrd;
    logic [4:0]  idexrt;
    logic [31:0] ifidins;
    logic        idjump;
    logic        exbranch;
    logic        exmemmemacc;
    logic        memready;
    logic        pcwr;
    logic        ifidwr;
    logic        pipewr;
    logic        ifidflush;
    logic        idexflush;
    logic [1:0]  hzstate;
    logic        memerr;
`ifdef HAZARD_STATS_EN
    logic [15:0] stallcnt;
    logic [15:0] flushcnt;
`endif

    int npass  = 0;
    int ntotal = 0;

    // Model state
    int exp_hz    = 0;
    int streak    = 0;
    bit exp_err   = 1'b0;
    int exp_stall = 0;
    int exp_flush = 0;

    hazardunit #(.MEMTIMEOUT(MT)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .idexmemrd  (idexmemrd),
        .idexrt     (idexrt),
        .ifidins    (ifidins),
        .idjump     (idjump),
        .exbranch   (exbranch),
        .exmemmemacc(exmemmemacc),
        .memready   (memready),
        .pcwr       (pcwr),
        .ifidwr     (ifidwr),
        .pipewr     (pipewr),
        .ifidflush  (ifidflush),
        .idexflush  (idexflush),
        .hzstate    (hzstate),
        .memerr     (memerr)
`ifdef HAZARD_STATS_EN
        ,
        .stallcnt   (stallcnt),
        .flushcnt   (flushcnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntotal++;
        assert (obs === exp) npass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Does the instruction read register r as a source?
    function automatic bit reads_reg(input logic [31:0] ins, input logic [4:0] r);
        int op;
        op = int'(ins[31:26]);
        if (op != 2 && op != 3 && ins[25:21] == r) return 1'b1;
        if ((op == 0 || op == 4 || op == 5) && ins[20:16] == r) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] mk_ins(input int op, input int rs, input int rt, input logic [15:0] low);
        return {6'(op), 5'(rs), 5'(rt), low};
    endfunction

    task automatic drive(input logic mrd, input logic [4:0] rt, input logic [31:0] ins,
                         input logic jmp, input logic br, input logic acc, input logic rdy);
        idexmemrd   = mrd;
        idexrt      = rt;
        ifidins     = ins;
        idjump      = jmp;
        exbranch    = br;
        exmemmemacc = acc;
        memready    = rdy;
    endtask

    // One clock cycle: check the combinational controls, clock, update the
    // model, check the registered state.
    task automatic step(input string tag);
        logic [4:0] ec;
        bit fz, lu, isstall;
        int c;
        fz = exmemmemacc && !memready;
        lu = idexmemrd && (idexrt != 5'd0) && reads_reg(ifidins, idexrt);
        isstall = 1'b0;
        // {pcwr, ifidwr, pipewr, ifidflush, idexflush}
        if (fz)            begin ec = 5'b00000; c = 3; end
        else if (exbranch) begin ec = 5'b11111; c = 2; end
        else if (lu)       begin ec = 5'b00101; c = 1; isstall = 1'b1; end
        else if (idjump)   begin ec = 5'b11110; c = 2; end
        else               begin ec = 5'b11100; c = 0; end
        #1;
        check({tag, "/ctl"}, 32'({pcwr, ifidwr, pipewr, ifidflush, idexflush}), 32'(ec));
        @(posedge clk);
        exp_hz = c;
        streak = fz ? streak + 1 : 0;
        if (streak >= int'(MT)) exp_err = 1'b1;
        if (isstall && exp_stall < 65535) exp_stall++;
        if (ec[1] && exp_flush < 65535) exp_flush++;
        #1;
        check({tag, "/hzstate"}, 32'(hzstate), 32'(exp_hz));
        check({tag, "/memerr"}, 32'(memerr), 32'(exp_err));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "/rst_ctl"}, 32'({pcwr, ifidwr, pipewr, ifidflush, idexflush}), 32'd0);
        check({tag, "/rst_hz"}, 32'(hzstate), 32'd0);
        check({tag, "/rst_err"}, 32'(memerr), 32'd0);
`ifdef HAZARD_STATS_EN
        check({tag, "/rst_stats"}, {stallcnt, flushcnt}, 32'd0);
`endif
    endtask

    // Pulse reset between edges, leaving the current inputs applied.
    task automatic pulse_reset(input string tag);
        @(negedge clk);
        #2;
        rstn = 1'b0;
        #1;
        check_reset_outputs(tag);
        exp_hz = 0; streak = 0; exp_err = 1'b0; exp_stall = 0; exp_flush = 0;
        @(negedge clk);
        #2;
        rstn = 1'b1;
    endtask

    initial begin
        logic [31:0] add_ins;
        logic [31:0] sw_ins;
        logic [5:0]  ops [8];
        ops[0] = 6'h00; ops[1] = 6'h04; ops[2] = 6'h05; ops[3] = 6'h02;
        ops[4] = 6'h03; ops[5] = 6'h23; ops[6] = 6'h2B; ops[7] = 6'h08;

        add_ins = mk_ins(0, 5, 2, 16'h1820);     // add $3,$5,$2
        sw_ins  = mk_ins(6'h2B, 4, 5, 16'h0000); // sw $5,0($4)

        rstn = 1'b0;
        drive(0, 0, 32'd0, 0, 0, 0, 1);
        #3;
        check_reset_outputs("init");
        #10;
        rstn = 1'b1;
        #1;

        // Load-use on rs, then the load moves on
        drive(1, 5'd5, add_ins, 0, 0, 0, 1);
        step("lduse_rs");
        drive(0, 5'd5, add_ins, 0, 0, 0, 1);
        step("after_stall");

        // Store data register does not stall; store address register does
        drive(1, 5'd5, sw_ins, 0, 0, 0, 1);
        step("sw_data");
        drive(1, 5'd4, sw_ins, 0, 0, 0, 1);
        step("sw_addr");

        // lduse on $0 never stalls
        drive(1, 5'd0, mk_ins(0, 0, 0, 16'h0020), 0, 0, 0, 1);
        step("lduse_r0");

        // Jump ignored under a load-use stall, then taken
        drive(1, 5'd5, add_ins, 1, 0, 0, 1);
        step("jump_under_stall");
        drive(0, 5'd5, add_ins, 1, 0, 0, 1);
        step("jump");

        // Branch beats load-use
        drive(1, 5'd5, add_ins, 0, 1, 0, 1);
        step("branch_over_lduse");

        // Freeze beats branch for 3 cycles, then the branch flush executes
        for (int i = 0; i < 3; i++) begin
            drive(1, 5'd5, add_ins, 1, 1, 1, 0);
            step("freeze_branch");
        end
        drive(1, 5'd5, add_ins, 1, 1, 1, 1);
        step("freeze_release");

        // Watchdog: memerr on the MT-th consecutive freeze edge, then sticky
        for (int i = 0; i < int'(MT) + 2; i++) begin
            drive(0, 5'd0, 32'd0, 0, 0, 1, 0);
            step("watchdog");
        end
        drive(0, 5'd0, 32'd0, 0, 0, 1, 1);
        step("watchdog_sticky");
        drive(0, 5'd0, 32'd0, 0, 0, 0, 0);
        step("watchdog_sticky2");

        // Async reset mid-freeze; watchdog restarts from 0 after release
        drive(0, 5'd0, 32'd0, 0, 0, 1, 0);
        step("pre_reset_freeze");
        step("pre_reset_freeze");
        pulse_reset("mid_freeze");
        #1;
        for (int i = 0; i < int'(MT) + 1; i++) step("post_reset_freeze");
        drive(0, 5'd0, 32'd0, 0, 0, 0, 1);
        step("post_reset_run");

        // Event tallies: 3 load-use stalls and 2 jumps
        pulse_reset("stats");
        #1;
        for (int i = 0; i < 3; i++) begin
            drive(1, 5'd5, add_ins, 0, 0, 0, 1);
            step("stats_stall");
            drive(0, 5'd0, add_ins, 0, 0, 0, 1);
            step("stats_run");
        end
        for (int i = 0; i < 2; i++) begin
            drive(0, 5'd0, add_ins, 1, 0, 0, 1);
            step("stats_jump");
        end
`ifdef HAZARD_STATS_EN
        check("stallcnt_dir", 32'(stallcnt), 32'd3);
        check("flushcnt_dir", 32'(flushcnt), 32'd2);
`endif

        // Randomized traffic against the model
        pulse_reset("random");
        #1;
        for (int n = 0; n < 400; n++) begin
            logic [31:0] ins;
            ins = mk_ins(int'(ops[$urandom_range(0, 7)]), int'($urandom_range(0, 7)),
                         int'($urandom_range(0, 7)), 16'($urandom));
            drive(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), ins,
                  ($urandom_range(0, 3) == 0), ($urandom_range(0, 6) == 0),
                  1'($urandom_range(0, 1)), ($urandom_range(0, 9) < 3));
            step("random");
        end
`ifdef HAZARD_STATS_EN
        check("stallcnt_rand", 32'(stallcnt), 32'(exp_stall));
        check("flushcnt_rand", 32'(flushcnt), 32'(exp_flush));
`endif

        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule
